design_example_param: RTL and testbench
=======================================

# design_example_param

Parametrised successor to the Start/A/E/F RTL design example. A control FSM drives a WIDTH-bit counter A and two flags, E and F. The stop condition and the bit that E tracks are both configurable. The block adds pause (Hold), cancel (Abort) and status (Busy, Done) signals, a defined datapath reset, and a defined recovery from the unused state code. It sits in the chapter's RTL examples as the reusable, generalised control-plus-datapath sequencer.

## Interface
- WIDTH, 4: width of counter A; legal range ≥ 2.
- E_BIT, 2: index of the A bit that E follows; legal range 0..WIDTH-1.
- STOP_MASK, 'b1100 (zero-extended to WIDTH): counting stops when every masked bit of A is 1; must be nonzero.
- clock  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  begins a run when sampled high in S_idle.
- Hold  input  1  pauses counting while in S_1.
- Abort  input  1  cancels a run from S_1.
- A  output  WIDTH  counter (register).
- E  output  1  tracked-bit flag (register).
- F  output  1  run-complete flag (register).
- Busy  output  1  high when state ≠ S_idle (decoded from state).
- Done  output  1  high while in S_2 (decoded from state).

## Operation
- State encoding is 2 bits: S_idle=00, S_1=01, S_2=11. Code 10 is unused.
- The datapath is a set of registers controlled by FSM decode signals. Only one action applies to a given register per edge.
- S_idle
  - Start=1: A←0, F←0, go to S_1. E is unchanged.
  - Start=0: stay in S_idle; no register changes.
- S_1, with priority Abort > Hold > count:
  - Abort=1: go to S_idle. A, E and F hold.
  - Hold=1: stay in S_1. A, E and F hold.
  - Otherwise, A←A+1 modulo 2^WIDTH and E←A[E_BIT], where E takes the pre-increment value.
    - If (A & STOP_MASK)==STOP_MASK, using the pre-increment A, go to S_2.
    - Otherwise stay in S_1.
- S_2: F←1, go to S_idle unconditionally. Start, Hold and Abort are ignored.
- Unused code 10: go to S_idle. No datapath action occurs, Busy=1, Done=0.
- Start is ignored outside S_idle. Start held high re-arms the block on the first cycle back in S_idle.
- Arithmetic: A wraps from all-ones to 0 with no carry output. Because STOP_MASK is nonzero and A wraps, every run terminates unless it is held or aborted.

## Timing
- Reset (asynchronous, high):
  - state←S_idle, A←0, E←0, F←0.
  - Busy=0, Done=0 while reset is held.
  - Reset asserted mid-run takes effect immediately and is not deferred to the next edge.
- The first edge after reset deasserts with Start=1 enters S_1 and sets A=0.
- With the defaults, each edge k in S_1 (no Hold) sets A=k.
  - The edge that sees A=12 (1100) sets A=13, E=1 and moves to S_2.
  - The next edge sets F=1 and returns to S_idle.
- Start-to-F latency is 1 + (cycles in S_1) + 1 edges. With the defaults this is 15 edges.
- Done is high for exactly one cycle per completed run. No Done is produced after an Abort.
- Hold stretches S_1 cycle for cycle.
- Abort on the final S_1 cycle, where the stop match is true, still wins: the next state is S_idle and F stays 0.
- Busy and Done are combinational decodes of the state register and are glitch-free relative to clock.

## Test plan
- Default parameters. Reset, then hold Start=1 for one cycle.
  - Required: A steps 0..13.
  - E is 0 until the edge with pre-value A=4, then follows bit 2 of the pre-increment A, ending at 1.
  - Done is high for one cycle, and F=1 fifteen edges after Start.
- Hold=1 for 3 cycles while A=5.
  - Required: A stays 5 and E holds.
  - F arrives 3 cycles later than in the first scenario.
- Abort=1 while A=7.
  - Required: next state S_idle, A=7, F=0, Busy=0, and Done is never asserted.
  - A following Start clears A to 0.
- Reset asserted asynchronously between edges while A=9 in S_1.
  - Required: A=0, E=0, F=0 and Busy=0 immediately.
  - Start is needed to restart.
- WIDTH=6, E_BIT=0, STOP_MASK='b100001.
  - Required: S_2 is entered after the edge with pre-value A=33, which sets A=34.
  - E toggles every count edge.
- Force state=10 via a bench force/release.
  - Required: the next edge gives S_idle with A, E and F unchanged.
  - Start=1 held through the end of S_2 re-enters S_1 on the S_idle cycle, which clears F.

Source files
------------

// File: rtl/design_example_param_if.sv
// rtl/design_example_param_if.sv - control/status bundle for the parametrised Start/A/E/F sequencer
interface design_example_param_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic             e;
  logic             f;
  logic             busy;
  logic             done;

  modport master (
    output start, hold, abort,
    input  a, e, f, busy, done
  );

  modport slave (
    input  start, hold, abort,
    output a, e, f, busy, done
  );
endinterface

// File: rtl/design_example_param.sv
// rtl/design_example_param.sv - control FSM driving counter A and flags E/F with hold, abort and status
module design_example_param #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      E_BIT     = 2,
  parameter logic [WIDTH-1:0] STOP_MASK = 4'b1100
) (
  input logic                  clk_i,
  input logic                  rst_i,
  design_example_param_if.slave seq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_1      = 2'b01,
    S_2      = 2'b11,
    S_UNUSED = 2'b10
  } state_e;

  // Kept as plain logic so the unused code can be held and recovered from.
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             e_q, e_d;
  logic             f_q, f_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = e_q;
    f_d     = f_q;
    case (state_q)
      S_IDLE: begin
        if (seq.start) begin
          a_d     = '0;
          f_d     = 1'b0;
          state_d = S_1;
        end
      end
      S_1: begin
        if (seq.abort) begin
          state_d = S_IDLE;
        end else if (!seq.hold) begin
          a_d = a_q + WIDTH'(1);
          e_d = a_q[E_BIT];
          // Stop test uses the pre-increment count.
          if ((a_q & STOP_MASK) == STOP_MASK) begin
            state_d = S_2;
          end
        end
      end
      S_2: begin
        f_d     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      e_q     <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      f_q     <= f_d;
    end
  end

  assign seq.a    = a_q;
  assign seq.e    = e_q;
  assign seq.f    = f_q;
  assign seq.busy = (state_q != S_IDLE);
  assign seq.done = (state_q == S_2);

endmodule

// File: tb/tb_design_example_param.sv
// tb/tb_design_example_param.sv - directed self-checking bench for design_example_param
module tb_design_example_param;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_cnt1;
  int   edges;
  int   dc;

  design_example_param_if #(.WIDTH(4)) if1 ();
  design_example_param_if #(.WIDTH(6)) if2 ();

  design_example_param #(
    .WIDTH(4), .E_BIT(2), .STOP_MASK(4'b1100)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .seq   (if1)
  );

  design_example_param #(
    .WIDTH(6), .E_BIT(0), .STOP_MASK(6'b100001)
  ) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .seq   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (if1.done) done_cnt1++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_cnt1 = 0;
    rst       = 1'b1;
    if1.start = 1'b0; if1.hold = 1'b0; if1.abort = 1'b0;
    if2.start = 1'b0; if2.hold = 1'b0; if2.abort = 1'b0;

    #2;
    check("rst_a",    32'(if1.a),    32'd0);
    check("rst_e",    32'(if1.e),    32'd0);
    check("rst_f",    32'(if1.f),    32'd0);
    check("rst_busy", 32'(if1.busy), 32'd0);
    check("rst_done", 32'(if1.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic run: 15 edges from Start to F
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("s1_busy", 32'(if1.busy), 32'd1);
    check("s1_a0",   32'(if1.a),    32'd0);
    check("s1_f0",   32'(if1.f),    32'd0);
    for (int i = 0; i < 13; i++) begin
      tick();
      check("run_a",    32'(if1.a),    32'(i + 1));
      check("run_e",    32'(if1.e),    32'((i >> 2) & 1));
      check("run_done", 32'(if1.done), 32'(i == 12));
    end
    tick();
    check("run_f",       32'(if1.f),    32'd1);
    check("run_idle",    32'(if1.busy), 32'd0);
    check("run_a_end",   32'(if1.a),    32'd13);
    check("run_e_end",   32'(if1.e),    32'd1);
    check("run_donecnt", 32'(done_cnt1), 32'd1);

    // Unused state code recovers to idle without touching the datapath
    force dut1.state_q = 2'b10;
    #1;
    check("unused_busy", 32'(if1.busy), 32'd1);
    check("unused_done", 32'(if1.done), 32'd0);
    release dut1.state_q;
    tick();
    check("unused_idle", 32'(if1.busy), 32'd0);
    check("unused_a",    32'(if1.a),    32'd13);
    check("unused_e",    32'(if1.e),    32'd1);
    check("unused_f",    32'(if1.f),    32'd1);

    // Hold for three cycles at A=5
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    edges = 1;
    check("hold_fclr", 32'(if1.f), 32'd0);
    check("hold_ekeep", 32'(if1.e), 32'd1);
    repeat (5) tick();
    edges += 5;
    check("hold_a5", 32'(if1.a), 32'd5);
    if1.hold = 1'b1;
    repeat (3) begin
      tick();
      edges++;
      check("hold_a",    32'(if1.a),    32'd5);
      check("hold_e",    32'(if1.e),    32'd1);
      check("hold_busy", 32'(if1.busy), 32'd1);
    end
    if1.hold = 1'b0;
    while (!if1.f && edges < 100) begin
      tick();
      edges++;
    end
    check("hold_latency", 32'(edges), 32'd18);

    // Abort at A=7
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (7) tick();
    check("abort_a7", 32'(if1.a), 32'd7);
    dc = done_cnt1;
    if1.abort = 1'b1;
    tick();
    if1.abort = 1'b0;
    check("abort_busy", 32'(if1.busy), 32'd0);
    check("abort_a",    32'(if1.a),    32'd7);
    check("abort_f",    32'(if1.f),    32'd0);
    repeat (2) tick();
    check("abort_stay", 32'(if1.busy), 32'd0);
    check("abort_a2",   32'(if1.a),    32'd7);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("abort_restart_a", 32'(if1.a),    32'd0);
    check("abort_restart_b", 32'(if1.busy), 32'd1);

    // Abort on the stop-match cycle still wins
    repeat (12) tick();
    check("abort12_a", 32'(if1.a), 32'd12);
    if1.abort = 1'b1;
    tick();
    if1.abort = 1'b0;
    check("abort12_busy", 32'(if1.busy), 32'd0);
    check("abort12_f",    32'(if1.f),    32'd0);
    check("abort12_a2",   32'(if1.a),    32'd12);
    check("abort_nodone", 32'(done_cnt1), 32'(dc));

    // Asynchronous reset between edges at A=9
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (9) tick();
    check("arst_a9", 32'(if1.a), 32'd9);
    #2 rst = 1'b1;
    #1;
    check("arst_a",    32'(if1.a),    32'd0);
    check("arst_e",    32'(if1.e),    32'd0);
    check("arst_f",    32'(if1.f),    32'd0);
    check("arst_busy", 32'(if1.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("arst_idle", 32'(if1.busy), 32'd0);
    check("arst_a0",   32'(if1.a),    32'd0);

    // Start held high re-arms on the first idle cycle
    if1.start = 1'b1;
    tick();
    repeat (13) tick();
    check("rearm_done", 32'(if1.done), 32'd1);
    check("rearm_a13",  32'(if1.a),    32'd13);
    tick();
    check("rearm_f1",   32'(if1.f),    32'd1);
    check("rearm_idle", 32'(if1.busy), 32'd0);
    tick();
    check("rearm_busy", 32'(if1.busy), 32'd1);
    check("rearm_a0",   32'(if1.a),    32'd0);
    check("rearm_f0",   32'(if1.f),    32'd0);
    if1.start = 1'b0;
    if1.abort = 1'b1;
    tick();
    if1.abort = 1'b0;
    check("rearm_abort", 32'(if1.busy), 32'd0);

    // WIDTH=6, E_BIT=0, STOP_MASK=100001
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    check("w6_busy", 32'(if2.busy), 32'd1);
    check("w6_a0",   32'(if2.a),    32'd0);
    for (int i = 0; i < 34; i++) begin
      tick();
      check("w6_a",    32'(if2.a),    32'(i + 1));
      check("w6_e",    32'(if2.e),    32'(i & 1));
      check("w6_done", 32'(if2.done), 32'(i == 33));
    end
    tick();
    check("w6_f",    32'(if2.f),    32'd1);
    check("w6_idle", 32'(if2.busy), 32'd0);
    check("w6_aend", 32'(if2.a),    32'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
